dtree_pipe: RTL and testbench

Parametrised successor to the three-feature spike-sorting decision tree. The block evaluates an oblique binary decision tree of configurable depth over a FEATURES-wide spike feature vector. Features stream in over a valid/ready handshake and are buffered. Each tree level computes sign(bias + Σ coeff·x) with a shared multiply-accumulate datapath. Per-node coefficients sit in a runtime-writable store, and the resulting leaf class is presented on a valid/ready output port.

---
 rtl/dtree_pipe.sv | 181 ++++++++++++++++++
 tb/tb_dtree_pipe.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dtree_pipe.sv
// rtl/dtree_pipe.sv - Oblique binary decision tree classifier over a buffered spike feature vector
// Ports:
//   clk, reset                        : rising-edge clock, asynchronous active-low reset
//   in_valid, in_ready, in_data       : feature beats, beat k carries feature k
//   cfg_we, cfg_addr, cfg_data        : coefficient store write, addr = node*(FEATURES+1)+k
//   cfg_err                           : pulses while a write is rejected (evaluation busy)
//   out_valid, out_ready, out_class   : leaf index, first decision in the MSB
module dtree_pipe #(
  parameter int FEATURES    = 3,
  parameter int IN_WIDTH    = 10,
  parameter int COEFF_WIDTH = 4,
  parameter int DEPTH       = 3,
  localparam int NODES      = (1 << DEPTH) - 1,
  localparam int SLOTS      = NODES * (FEATURES + 1),
  localparam int CFG_AW     = $clog2(SLOTS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [IN_WIDTH-1:0] in_data,
  input  logic                cfg_we,
  input  logic [CFG_AW-1:0]   cfg_addr,
  input  logic [IN_WIDTH-1:0] cfg_data,
  output logic                cfg_err,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DEPTH-1:0]    out_class
);

  localparam int STEP_W = $clog2(FEATURES + 1);
  localparam int LVL_W  = $clog2(DEPTH + 1);
  localparam int NODE_W = DEPTH + 1;
  localparam int ACC_W  = IN_WIDTH + 1 + STEP_W;
  localparam int PROD_W = IN_WIDTH + COEFF_WIDTH;

  typedef enum logic [1:0] {COLLECT, EVAL, DONE} state_t;

  state_t                  state_q, state_d;
  logic [STEP_W-1:0]       count_q, count_d;
  logic [STEP_W-1:0]       step_q, step_d;
  logic [LVL_W-1:0]        level_q, level_d;
  logic [NODE_W-1:0]       node_q, node_d;
  logic [DEPTH-1:0]        path_q, path_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;

  logic [IN_WIDTH-1:0]     feat_q [FEATURES];
  logic [IN_WIDTH-1:0]     store_q [SLOTS];
  logic                    feat_we;

  logic [STEP_W-1:0]            feat_sel;
  logic [CFG_AW-1:0]            rd_idx;
  logic [IN_WIDTH-1:0]          rd_word;
  logic signed [IN_WIDTH-1:0]   x_sel;
  logic signed [COEFF_WIDTH-1:0] coeff;
  logic                         is_one;
  logic signed [PROD_W-1:0]     prod;
  logic signed [IN_WIDTH:0]     term;
  logic signed [ACC_W-1:0]      sum;
  logic                         dir;
  logic                         last_step;
  logic                         last_level;

  // Shared MAC datapath: step 0 reads the node bias, step s reads coefficient s-1.
  always_comb begin
    feat_sel = (step_q == '0) ? '0 : step_q - STEP_W'(1);
    rd_idx   = CFG_AW'(node_q) * CFG_AW'(FEATURES + 1)
             + ((step_q == '0) ? CFG_AW'(FEATURES) : CFG_AW'(feat_sel));
    rd_word  = store_q[rd_idx];
    x_sel    = signed'(feat_q[feat_sel]);
    coeff    = signed'(rd_word[COEFF_WIDTH-1:0]);
    is_one   = rd_word[COEFF_WIDTH];
    prod     = PROD_W'(x_sel) * PROD_W'(coeff);
    // Q1.(COEFF_WIDTH-1) rescale: arithmetic shift floors toward minus infinity.
    term     = is_one ? {x_sel[IN_WIDTH-1], x_sel}
                      : (IN_WIDTH + 1)'(prod >>> (COEFF_WIDTH - 1));
    sum      = acc_q + ACC_W'(term);
    dir      = ~sum[ACC_W-1];
    last_step  = (step_q == STEP_W'(FEATURES));
    last_level = (level_q == LVL_W'(DEPTH - 1));
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    step_d    = step_q;
    level_d   = level_q;
    node_d    = node_q;
    path_d    = path_q;
    acc_d     = acc_q;
    feat_we   = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    cfg_err   = 1'b0;
    case (state_q)
      COLLECT: begin
        in_ready = 1'b1;
        if (in_valid) begin
          feat_we = 1'b1;
          count_d = count_q + STEP_W'(1);
          if (count_q == STEP_W'(FEATURES - 1)) begin
            state_d = EVAL;
            count_d = '0;
            step_d  = '0;
            level_d = '0;
            node_d  = '0;
            path_d  = '0;
          end
        end
      end
      EVAL: begin
        cfg_err = cfg_we;
        if (step_q == '0) begin
          acc_d  = ACC_W'(signed'(rd_word));
          step_d = step_q + STEP_W'(1);
        end else begin
          acc_d = sum;
          if (last_step) begin
            step_d  = '0;
            // Heap numbering: children of node n are 2n+1 (left) and 2n+2 (right).
            node_d  = (node_q << 1) + NODE_W'(1) + NODE_W'(dir);
            path_d  = (path_q << 1) | DEPTH'(dir);
            level_d = level_q + LVL_W'(1);
            if (last_level) begin
              state_d = DONE;
            end
          end else begin
            step_d = step_q + STEP_W'(1);
          end
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = COLLECT;
          count_d = '0;
        end
      end
      default: begin
        state_d = COLLECT;
      end
    endcase
  end

  assign out_class = path_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= COLLECT;
      count_q <= '0;
      step_q  <= '0;
      level_q <= '0;
      node_q  <= '0;
      path_q  <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      step_q  <= step_d;
      level_q <= level_d;
      node_q  <= node_d;
      path_q  <= path_d;
      acc_q   <= acc_d;
    end
  end

  // Feature buffer and coefficient store survive reset; the store is only
  // frozen while an evaluation is reading it.
  always_ff @(posedge clk) begin
    if (feat_we) begin
      feat_q[count_q] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (cfg_we && (state_q != EVAL) && (32'(cfg_addr) < 32'(SLOTS))) begin
      store_q[cfg_addr] <= cfg_data;
    end
  end

endmodule

// File: tb/tb_dtree_pipe.sv
// tb/tb_dtree_pipe.sv - Directed table-driven bench for dtree_pipe
module tb_dtree_pipe;

  localparam int F     = 3;
  localparam int IW    = 10;
  localparam int CW    = 4;
  localparam int D     = 3;
  localparam int NODES = 7;
  localparam int AW    = 5;
  localparam int LAT   = 12;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [IW-1:0] in_data;
  logic          cfg_we;
  logic [AW-1:0] cfg_addr;
  logic [IW-1:0] cfg_data;
  logic          cfg_err;
  logic          out_valid;
  logic          out_ready;
  logic [D-1:0]  out_class;

  always #5 clk = ~clk;

  dtree_pipe #(
    .FEATURES(F), .IN_WIDTH(IW), .COEFF_WIDTH(CW), .DEPTH(D)
  ) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_err(cfg_err),
    .out_valid(out_valid), .out_ready(out_ready), .out_class(out_class)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    int mode;
    int x0;
    int x1;
    int x2;
    int cls;
  } vec_t;

  vec_t tbl [16];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Modes: 0 sign routing, 1 threshold, 2/3 extremes, 4 per-node thresholds, 5 mixed coeffs.
  function automatic logic [IW-1:0] cfg_word(input int mode, input int n, input int k);
    int thr;
    case (n)
      0: thr = 0;
      1: thr = -20;
      2: thr = 20;
      3: thr = -30;
      4: thr = -10;
      5: thr = 10;
      default: thr = 30;
    endcase
    case (mode)
      0: return (k == 0) ? 10'h010 : 10'h000;
      1: return (k == 0) ? 10'h004 : ((k == 3) ? 10'(-25) : 10'h000);
      2: return (k == 3) ? 10'(-512) : 10'h010;
      3: return (k == 3) ? 10'(511) : 10'h010;
      4: return (k == 0) ? 10'h010 : ((k == 3) ? 10'(-thr) : 10'h000);
      default: begin
        case (k)
          0: return 10'h004;
          1: return 10'h008;
          2: return 10'h002;
          default: return 10'h000;
        endcase
      end
    endcase
  endfunction

  task automatic cfg_write(input int addr, input logic [IW-1:0] data);
    cfg_we   = 1'b1;
    cfg_addr = AW'(addr);
    cfg_data = data;
    tick();
    cfg_we   = 1'b0;
  endtask

  task automatic program_mode(input int mode);
    for (int n = 0; n < NODES; n++) begin
      for (int k = 0; k <= F; k++) begin
        cfg_write(n * (F + 1) + k, cfg_word(mode, n, k));
      end
    end
  endtask

  task automatic send_vec(input int x0, input int x1, input int x2);
    int xs [3];
    int guard;
    xs[0] = x0;
    xs[1] = x1;
    xs[2] = x2;
    for (int k = 0; k < F; k++) begin
      in_valid = 1'b1;
      in_data  = IW'(xs[k]);
      guard = 0;
      while (!in_ready && guard < 100) begin
        tick();
        guard++;
      end
      if (!in_ready) check("in_ready_timeout", 0, 1);
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    while (!out_valid && lat < 100) begin
      tick();
      lat++;
    end
  endtask

  task automatic take_result();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic run_vec(input string name, input int x0, input int x1, input int x2,
                         input int cls);
    int lat;
    send_vec(x0, x1, x2);
    wait_result(lat);
    check({name, "_latency"}, lat, LAT);
    check({name, "_class"}, int'(out_class), cls);
    take_result();
    check({name, "_in_ready_after"}, int'(in_ready), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int cur_mode;

    reset     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    cfg_we    = 1'b0;
    cfg_addr  = '0;
    cfg_data  = '0;
    out_ready = 1'b0;

    tbl[0]  = '{0,    5,   -3,    7, 7};
    tbl[1]  = '{0,   -5,    3,    7, 0};
    tbl[2]  = '{1,   50,    0,    0, 7};
    tbl[3]  = '{1,   48,    0,    0, 0};
    tbl[4]  = '{2, -512, -512, -512, 0};
    tbl[5]  = '{2,  511,  511,  511, 7};
    tbl[6]  = '{3,  511,  511,  511, 7};
    tbl[7]  = '{4,  -25,    0,    0, 1};
    tbl[8]  = '{4,   15,    0,    0, 5};
    tbl[9]  = '{4,  -35,    0,    0, 0};
    tbl[10] = '{4,   35,    0,    0, 7};
    tbl[11] = '{4,    0,    0,    0, 4};
    tbl[12] = '{4,  -10,    0,    0, 3};
    tbl[13] = '{5,   10,    3,   -7, 7};
    tbl[14] = '{5,   10,    4,   -7, 0};
    tbl[15] = '{4,   25,    9,   -9, 6};

    tick();
    tick();
    reset = 1'b1;
    #1;
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_class", int'(out_class), 0);
    check("rst_cfg_err", int'(cfg_err), 0);

    cur_mode = -1;
    for (int i = 0; i < 16; i++) begin
      if (tbl[i].mode != cur_mode) begin
        program_mode(tbl[i].mode);
        cur_mode = tbl[i].mode;
      end
      run_vec($sformatf("vec%0d", i), tbl[i].x0, tbl[i].x1, tbl[i].x2, tbl[i].cls);
    end

    // Backpressure: result held, in_ready low, stray beats ignored.
    program_mode(0);
    send_vec(5, -3, 7);
    wait_result(lat);
    check("bp_latency", lat, LAT);
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1;
      in_data  = IW'(-100);
      #1;
      check("bp_out_valid", int'(out_valid), 1);
      check("bp_out_class", int'(out_class), 7);
      check("bp_in_ready", int'(in_ready), 0);
      tick();
    end
    in_valid = 1'b0;
    take_result();
    check("bp_in_ready_after", int'(in_ready), 1);
    check("bp_out_valid_after", int'(out_valid), 0);
    run_vec("bp_next", -5, 3, 7, 0);

    // Reset during level 1 of the evaluation.
    send_vec(5, -3, 7);
    repeat (5) tick();
    reset = 1'b0;
    #1;
    check("midrst_in_ready", int'(in_ready), 1);
    check("midrst_out_valid", int'(out_valid), 0);
    check("midrst_out_class", int'(out_class), 0);
    check("midrst_cfg_err", int'(cfg_err), 0);
    tick();
    reset = 1'b1;
    run_vec("midrst_resend", 5, -3, 7, 7);

    // Write during EVAL is rejected; the same write in DONE is accepted.
    send_vec(5, -3, 7);
    tick();
    tick();
    cfg_we   = 1'b1;
    cfg_addr = AW'(3);
    cfg_data = IW'(-100);
    #1;
    check("eval_cfg_err_high", int'(cfg_err), 1);
    tick();
    cfg_we = 1'b0;
    #1;
    check("eval_cfg_err_low", int'(cfg_err), 0);
    wait_result(lat);
    check("eval_cfg_class", int'(out_class), 7);
    cfg_we = 1'b1;
    #1;
    check("done_cfg_err", int'(cfg_err), 0);
    tick();
    cfg_we = 1'b0;
    check("done_cfg_out_valid", int'(out_valid), 1);
    take_result();
    run_vec("done_cfg_next", 5, -3, 7, 3);
    cfg_write(3, 10'h000);

    // Write on the final feature handshake is visible to that evaluation.
    in_valid = 1'b1;
    in_data  = IW'(5);
    tick();
    in_data  = IW'(-3);
    tick();
    in_data  = IW'(7);
    cfg_we   = 1'b1;
    cfg_addr = AW'(3);
    cfg_data = IW'(-100);
    #1;
    check("last_beat_cfg_err", int'(cfg_err), 0);
    tick();
    in_valid = 1'b0;
    cfg_we   = 1'b0;
    wait_result(lat);
    check("last_beat_cfg_latency", lat, LAT);
    check("last_beat_cfg_class", int'(out_class), 3);
    take_result();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
